// File: rtl/bg_mean_estimator.sv
// Mean background colour: accumulates NUM_PE per-PE sums per channel, then divides by NUM_PE*PIX_PER_PE.
// Build option: define BG_MEAN_ROUND_EN for round-half-up; otherwise the quotient is truncated.
module bg_mean_estimator #(
   parameter int NUM_PE     = 4,
   parameter int PIX_PER_PE = 1,
   parameter int SUM_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             sum_valid,
   output logic             sum_ready,
   input  logic [SUM_W-1:0] red_sum_in,
   input  logic [SUM_W-1:0] green_sum_in,
   input  logic [SUM_W-1:0] blue_sum_in,
   output logic [7:0]       red_exp,
   output logic [7:0]       green_exp,
   output logic [7:0]       blue_exp,
   output logic             Done,
   input  logic             Ack,
   output logic             Qi,
   output logic             Qa,
   output logic             Qdv,
   output logic             Qd
);
   localparam int ACC_W = SUM_W + $clog2(NUM_PE) + 1;
   localparam int D     = NUM_PE * PIX_PER_PE;
   localparam int REM_W = $clog2(D) + 2;
   localparam int PC_W  = $clog2(NUM_PE) + 1;
   localparam int BC_W  = $clog2(ACC_W) + 1;
   localparam logic [REM_W:0] D_R = (REM_W+1)'(D);
`ifdef BG_MEAN_ROUND_EN
   localparam logic [ACC_W-1:0] RND = ACC_W'(D / 2);
`else
   localparam logic [ACC_W-1:0] RND = '0;
`endif

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_ACCUM  = 4'b0010,
      S_DIVIDE = 4'b0100,
      S_DONE   = 4'b1000
   } state_t;

   state_t           r_state, w_state_next;
   logic [PC_W-1:0]  r_pe_cnt;
   logic [BC_W-1:0]  r_bit_cnt;
   logic             w_start_go, w_beat, w_last_beat, w_div_last;
   logic [SUM_W-1:0] w_sum_in [3];
   logic [7:0]       w_exp    [3];

   assign w_start_go  = Start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_beat      = sum_valid && (r_state == S_ACCUM);
   assign w_last_beat = w_beat && (r_pe_cnt == PC_W'(NUM_PE - 1));
   assign w_div_last  = (r_state == S_DIVIDE) && (r_bit_cnt == '0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (Start) w_state_next = S_ACCUM;
         S_ACCUM:  if (w_last_beat) w_state_next = S_DIVIDE;
         S_DIVIDE: if (r_bit_cnt == '0) w_state_next = S_DONE;
         S_DONE: begin
            // Start has priority over Ack so a new frame can chain directly
            if (Start)    w_state_next = S_ACCUM;
            else if (Ack) w_state_next = S_IDLE;
         end
         default:  w_state_next = S_IDLE;
      endcase
   end

   assign sum_ready = (r_state == S_ACCUM);
   assign Done      = (r_state == S_DONE);
   assign {Qd, Qdv, Qa, Qi} = r_state;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_pe_cnt  <= '0;
         r_bit_cnt <= '0;
      end else begin
         if (w_start_go)  r_pe_cnt <= '0;
         else if (w_beat) r_pe_cnt <= r_pe_cnt + PC_W'(1);
         if (w_last_beat) r_bit_cnt <= BC_W'(ACC_W - 1);
         else if (r_state == S_DIVIDE && r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - BC_W'(1);
      end
   end

   assign w_sum_in[0] = red_sum_in;
   assign w_sum_in[1] = green_sum_in;
   assign w_sum_in[2] = blue_sum_in;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         logic [ACC_W-1:0] r_acc;
         logic [REM_W-1:0] r_rem;
         logic [7:0]       r_exp;
         logic [REM_W:0]   w_rem_sh, w_rem_nxt;
         logic             w_qbit, w_unused_rem;
         logic [ACC_W-1:0] w_acc_add, w_quot;

         // r_acc doubles as the dividend shift register; quotient bits enter at the LSB
         assign w_rem_sh     = {r_rem, r_acc[ACC_W-1]};
         assign w_qbit       = (w_rem_sh >= D_R);
         assign w_rem_nxt    = w_qbit ? (w_rem_sh - D_R) : w_rem_sh;
         assign w_unused_rem = w_rem_nxt[REM_W];
         assign w_acc_add    = r_acc + ACC_W'(w_sum_in[gi]);
         assign w_quot       = {r_acc[ACC_W-2:0], w_qbit};
         assign w_exp[gi]    = r_exp;

         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
               r_acc <= '0;
               r_rem <= '0;
               r_exp <= '0;
            end else if (w_start_go) begin
               r_acc <= '0;
               r_rem <= '0;
            end else if (w_beat) begin
               r_acc <= w_last_beat ? (w_acc_add + RND) : w_acc_add;
            end else if (r_state == S_DIVIDE) begin
               r_acc <= w_quot;
               r_rem <= w_rem_nxt[REM_W-1:0];
               if (w_div_last) r_exp <= (|w_quot[ACC_W-1:8]) ? 8'hFF : w_quot[7:0];
            end
         end
      end
   endgenerate

   assign red_exp   = w_exp[0];
   assign green_exp = w_exp[1];
   assign blue_exp  = w_exp[2];
endmodule

// File: tb/tb_bg_mean_estimator.sv
// Bench for bg_mean_estimator: directed frames plus randomized sums against an arithmetic mean model.
module tb_bg_mean_estimator;
   localparam int NUM_PE = 4;
   localparam int ACC_W  = 19;
   localparam int D      = 4;
`ifdef BG_MEAN_ROUND_EN
   localparam int RND = D / 2;
`else
   localparam int RND = 0;
`endif

   logic        Clk = 1'b0;
   logic        Reset_n, Start, sum_valid, Ack;
   logic [15:0] red_sum_in, green_sum_in, blue_sum_in;
   logic        sum_ready, Done, Qi, Qa, Qdv, Qd;
   logic [7:0]  red_exp, green_exp, blue_exp;

   always #5 Clk = ~Clk;

   bg_mean_estimator #(.NUM_PE(4), .PIX_PER_PE(1), .SUM_W(16)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .sum_valid(sum_valid), .sum_ready(sum_ready),
      .red_sum_in(red_sum_in), .green_sum_in(green_sum_in), .blue_sum_in(blue_sum_in),
      .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
      .Done(Done), .Ack(Ack), .Qi(Qi), .Qa(Qa), .Qdv(Qdv), .Qd(Qd)
   );

   int n_chk = 0;
   int n_fail = 0;
   int fr_r[4], fr_g[4], fr_b[4];
   int m_r = 0, m_g = 0, m_b = 0;

   function automatic int mean_of(input int s0, input int s1, input int s2, input int s3);
      int q;
      q = (s0 + s1 + s2 + s3 + RND) / D;
      return (q > 255) ? 255 : q;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic set_frame(input int r0, r1, r2, r3, input int g0, g1, g2, g3, input int b0, b1, b2, b3);
      fr_r = '{r0, r1, r2, r3};
      fr_g = '{g0, g1, g2, g3};
      fr_b = '{b0, b1, b2, b3};
   endtask

   // Starts a frame (optionally with Ack in the same cycle), feeds four beats and checks the result
   task automatic run_frame(input string tag, input bit gaps, input bit with_ack);
      int  idx, cyc, lat;
      bit  acc_now;
      @(negedge Clk);
      Start = 1'b1; Ack = with_ack;
      @(negedge Clk);
      Start = 1'b0; Ack = 1'b0;
      chk({tag, "/in_accum"}, {Qd, Qdv, Qa, Qi}, 4'b0010);
      chk({tag, "/ready"}, sum_ready, 1);
      chk({tag, "/held_accum"}, red_exp, m_r);
      idx = 0; cyc = 0;
      while (idx < NUM_PE && cyc < 200) begin
         sum_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sum_valid) begin
            red_sum_in = 16'(fr_r[idx]); green_sum_in = 16'(fr_g[idx]); blue_sum_in = 16'(fr_b[idx]);
         end else begin
            red_sum_in = 16'($urandom); green_sum_in = 16'($urandom); blue_sum_in = 16'($urandom);
         end
         acc_now = sum_valid && sum_ready;
         @(negedge Clk);
         cyc++;
         if (acc_now) idx++;
      end
      chk({tag, "/beats"}, idx, NUM_PE);
      lat = 1;
      sum_valid = 1'b1;
      red_sum_in = 16'hFFFF; green_sum_in = 16'hFFFF; blue_sum_in = 16'hFFFF;
      chk({tag, "/ready_drop"}, sum_ready, 0);
      chk({tag, "/in_divide"}, Qdv, 1);
      chk({tag, "/held_divide"}, red_exp, m_r);
      while (!Done && lat < 100) begin
         Start = (lat == 3);
         @(negedge Clk);
         lat++;
      end
      Start = 1'b0; sum_valid = 1'b0;
      chk({tag, "/latency"}, lat, ACC_W + 1);
      m_r = mean_of(fr_r[0], fr_r[1], fr_r[2], fr_r[3]);
      m_g = mean_of(fr_g[0], fr_g[1], fr_g[2], fr_g[3]);
      m_b = mean_of(fr_b[0], fr_b[1], fr_b[2], fr_b[3]);
      chk({tag, "/red"}, red_exp, m_r);
      chk({tag, "/green"}, green_exp, m_g);
      chk({tag, "/blue"}, blue_exp, m_b);
      chk({tag, "/done_state"}, {Qd, Qdv, Qa, Qi}, 4'b1000);
      $display("frame %s: r=%0d g=%0d b=%0d latency=%0d", tag, red_exp, green_exp, blue_exp, lat);
   endtask

   task automatic ack_frame(input string tag);
      @(negedge Clk); Ack = 1'b1;
      @(negedge Clk); Ack = 1'b0;
      chk({tag, "/idle"}, {Qd, Qdv, Qa, Qi}, 4'b0001);
      chk({tag, "/done_low"}, Done, 0);
      chk({tag, "/held_idle"}, red_exp, m_r);
   endtask

   initial begin
      Reset_n = 1'b0; Start = 1'b0; Ack = 1'b0; sum_valid = 1'b0;
      red_sum_in = '0; green_sum_in = '0; blue_sum_in = '0;
      repeat (3) @(negedge Clk);
      chk("reset/state", {Qd, Qdv, Qa, Qi}, 4'b0001);
      chk("reset/ready", sum_ready, 0);
      chk("reset/done", Done, 0);
      chk("reset/red", red_exp, 0);
      Reset_n = 1'b1;

      // Beats offered in IDLE must be ignored
      repeat (3) begin
         sum_valid = 1'b1;
         red_sum_in = 16'($urandom); green_sum_in = 16'($urandom); blue_sum_in = 16'($urandom);
         @(negedge Clk);
         chk("idle/ready", sum_ready, 0);
         chk("idle/state", Qi, 1);
      end
      sum_valid = 1'b0;

      set_frame(10, 20, 30, 40, 10, 20, 30, 40, 10, 20, 30, 40);
      run_frame("basic", 1'b0, 1'b0);
      ack_frame("basic");

      set_frame(25, 25, 26, 26, 0, 0, 0, 3, 300, 300, 300, 300);
      run_frame("round", 1'b1, 1'b0);

      // Chained from DONE with Start and Ack together
      set_frame(300, 300, 300, 300, 1, 2, 3, 4, 65535, 65535, 65535, 65535);
      run_frame("chain", 1'b1, 1'b1);

      for (int k = 0; k < 6; k++) begin
         int lim;
         lim = (k % 2 == 0) ? 1100 : 65535;
         set_frame($urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
                   $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
                   $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim));
         run_frame($sformatf("rand%0d", k), 1'b1, 1'b0);
         if (k % 3 == 2) ack_frame($sformatf("rand%0d", k));
      end

      // Reset asserted in the middle of a division
      @(negedge Clk); Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
         sum_valid = 1'b1; red_sum_in = 16'd400; green_sum_in = 16'd400; blue_sum_in = 16'd400;
         @(negedge Clk);
      end
      sum_valid = 1'b0;
      repeat (5) @(negedge Clk);
      chk("middiv/dividing", Qdv, 1);
      Reset_n = 1'b0;
      #1;
      chk("middiv/state", {Qd, Qdv, Qa, Qi}, 4'b0001);
      chk("middiv/red", red_exp, 0);
      chk("middiv/done", Done, 0);
      chk("middiv/ready", sum_ready, 0);
      m_r = 0; m_g = 0; m_b = 0;
      @(negedge Clk); Reset_n = 1'b1;
      set_frame(7, 8, 9, 10, 100, 200, 300, 401, 1000, 0, 0, 1);
      run_frame("after_reset", 1'b1, 1'b0);
      ack_frame("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
